// File: rtl/rr_mux2_pkg.sv
// Shared constants for the round-robin 2:1 stream merger.
package rr_mux2_pkg;
   localparam logic SEL_A     = 1'b0;
   localparam logic SEL_B     = 1'b1;
   localparam int   DEF_WIDTH = 8;
   localparam int   DEF_CNT_W = 16;
endpackage

// File: rtl/rr_mux2_stage_if.sv
// Bundle of the two source streams and the merged output stream.
interface rr_mux2_stage_if
   import rr_mux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_sel;
   logic             out_ready;

   // Environment side: owns both sources and the downstream sink.
   modport master (
      output a_valid, a_data, b_valid, b_data, out_ready,
      input  a_ready, b_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, out_ready,
      output a_ready, b_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: priority pointer plus grant/ready logic.
module rr_arb2
   import rr_mux2_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       load_en,
   output logic [1:0] gnt,
   output logic [1:0] rdy
);
   logic ptr;

   // The pointer moves to the loser only when a word is actually taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= SEL_A;
      end else if (load_en && (gnt != 2'b00)) begin
         ptr <= gnt[0];
      end
   end

   // Readies look only at the other source's valid, never their own.
   always_comb begin
      gnt    = 2'b00;
      rdy    = 2'b00;
      gnt[0] = req[0] && (!req[1] || (ptr == SEL_A));
      gnt[1] = req[1] && (!req[0] || (ptr == SEL_B));
      rdy[0] = load_en && (!req[1] || (ptr == SEL_A));
      rdy[1] = load_en && (!req[0] || (ptr == SEL_B));
   end
endmodule

// File: rtl/rr_mux2_stage.sv
// Round-robin 2:1 stream merger with a one-entry output register.
// Define GRANT_CNT_EN to add saturating per-source grant counters cnt_a/cnt_b.
module rr_mux2_stage
   import rr_mux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_mux2_stage_if.slave   bus
`ifdef GRANT_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
`endif
);
   logic             load_en;
   logic [1:0]       req;
   logic [1:0]       gnt;
   logic [1:0]       rdy;
   logic             xfer_a;
   logic             xfer_b;
   logic             vld_p1;
   logic [WIDTH-1:0] data_p1;
   logic             sel_p1;

   // Gated by rst_n so nothing is handshaken while the stage is held in reset.
   assign load_en = rst_n && (!vld_p1 || bus.out_ready);
   assign req     = {bus.b_valid, bus.a_valid};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .load_en (load_en),
      .gnt     (gnt),
      .rdy     (rdy)
   );

   assign bus.a_ready = rdy[0];
   assign bus.b_ready = rdy[1];
   assign xfer_a      = gnt[0] && load_en;
   assign xfer_b      = gnt[1] && load_en;

   // ---- stage p1: output register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sel_p1  <= SEL_A;
      end else if (xfer_a || xfer_b) begin
         vld_p1  <= 1'b1;
         data_p1 <= xfer_b ? bus.b_data : bus.a_data;
         sel_p1  <= xfer_b ? SEL_B : SEL_A;
      end else if (bus.out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_sel   = sel_p1;

`ifdef GRANT_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (xfer_a) cnt_a <= sat_inc(cnt_a);
         if (xfer_b) cnt_b <= sat_inc(cnt_b);
      end
   end
`endif
endmodule

// File: tb/tb_rr_mux2_stage.sv
// Scoreboard bench for rr_mux2_stage: directed stimulus pushes expected words, a monitor pops them.
module tb_rr_mux2_stage;
   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   int   ia;
   int   ib;

   rr_mux2_stage_if #(.WIDTH(WIDTH)) bus ();

`ifdef GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
`endif

   rr_mux2_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef GRANT_CNT_EN
      ,
      .cnt_a (cnt_a),
      .cnt_b (cnt_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic s);
      exp_q.push_back({s, d});
   endtask

   // Monitor: every accepted output word must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_word: unexpected word %h sel %0d, expected none",
                     bus.out_data, bus.out_sel);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_word", {23'b0, bus.out_sel, bus.out_data}, {23'b0, mon_e});
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n         = 1'b0;
      bus.a_valid   = 1'b1;
      bus.a_data    = 8'h55;
      bus.b_valid   = 1'b0;
      bus.b_data    = 8'h00;
      bus.out_ready = 1'b1;

      // 1. reset with A pending, then A served first
      step();
      step();
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, bus.out_data}, 32'h00);
      chk("rst_out_sel", {31'b0, bus.out_sel}, 32'd0);
      chk("rst_a_ready", {31'b0, bus.a_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_a_ready", {31'b0, bus.a_ready}, 32'd1);
      push(8'h55, 1'b0);
      step();
      bus.a_valid = 1'b0;
      step();
      chk("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);

      // 4. single source B, no bubbles
      bus.b_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.b_data = 8'(i);
         #1;
         chk("single_b_ready", {31'b0, bus.b_ready}, 32'd1);
         push(8'(i), 1'b1);
         step();
         chk("single_out_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      bus.b_valid = 1'b0;
      step();

      // 2. contention alternates A,B starting with A
      ia = 0;
      ib = 0;
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.a_data = 8'(8'hA0 + ia);
         bus.b_data = 8'(8'hB0 + ib);
         #1;
         if (k % 2 == 0) begin
            chk("cont_a_ready", {31'b0, bus.a_ready}, 32'd1);
            chk("cont_b_ready", {31'b0, bus.b_ready}, 32'd0);
            push(8'(8'hA0 + ia), 1'b0);
            ia++;
         end else begin
            chk("cont_a_ready", {31'b0, bus.a_ready}, 32'd0);
            chk("cont_b_ready", {31'b0, bus.b_ready}, 32'd1);
            push(8'(8'hB0 + ib), 1'b1);
            ib++;
         end
         step();
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      step();

      // 3. backpressure holds 3C, then B (pointer favoured) loads in the drain edge
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h3C;
      push(8'h3C, 1'b0);
      step();
      bus.out_ready = 1'b0;
      bus.a_data    = 8'h3D;
      bus.b_valid   = 1'b1;
      bus.b_data    = 8'hC3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_a_ready", {31'b0, bus.a_ready}, 32'd0);
         chk("stall_b_ready", {31'b0, bus.b_ready}, 32'd0);
         chk("stall_out_data", {24'b0, bus.out_data}, 32'h3C);
         chk("stall_out_sel", {31'b0, bus.out_sel}, 32'd0);
         chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("unstall_a_ready", {31'b0, bus.a_ready}, 32'd0);
      chk("unstall_b_ready", {31'b0, bus.b_ready}, 32'd1);
      push(8'hC3, 1'b1);
      step();
      chk("reload_out_valid", {31'b0, bus.out_valid}, 32'd1);
      bus.b_valid = 1'b0;
      #1;
      chk("after_b_a_ready", {31'b0, bus.a_ready}, 32'd1);
      push(8'h3D, 1'b0);
      step();
      bus.a_valid = 1'b0;
      step();
      chk("bp_drain_valid", {31'b0, bus.out_valid}, 32'd0);

      // 5. reset while stalled on 77 drops it and restores A priority
      bus.out_ready = 1'b0;
      bus.a_valid   = 1'b1;
      bus.a_data    = 8'h77;
      step();
      bus.a_valid = 1'b0;
      #1;
      chk("hold77_data", {24'b0, bus.out_data}, 32'h77);
      chk("hold77_valid", {31'b0, bus.out_valid}, 32'd1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("midrst_out_data", {24'b0, bus.out_data}, 32'h00);
      bus.out_ready = 1'b1;
      bus.a_valid   = 1'b1;
      bus.a_data    = 8'hE1;
      bus.b_valid   = 1'b1;
      bus.b_data    = 8'hE2;
      #1;
      chk("midrst_a_ready", {31'b0, bus.a_ready}, 32'd1);
      chk("midrst_b_ready", {31'b0, bus.b_ready}, 32'd0);
      push(8'hE1, 1'b0);
      step();
      bus.a_valid = 1'b0;
      push(8'hE2, 1'b1);
      step();
      bus.b_valid = 1'b0;
      step();

      // 6. five A transfers and one B transfer after a fresh reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.a_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.a_data = 8'(8'hF0 + i);
         push(8'(8'hF0 + i), 1'b0);
         step();
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b1;
      bus.b_data  = 8'h5A;
      push(8'h5A, 1'b1);
      step();
      bus.b_valid = 1'b0;
      step();
      step();
`ifdef GRANT_CNT_EN
      chk("cnt_a_sat", 32'(cnt_a), 32'd3);
      chk("cnt_b", 32'(cnt_b), 32'd1);
`endif
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
